// File: rtl/seq_shift_add_mult.sv
// Unsigned NxN sequential shift-and-add multiplier. It makes one add/shift step
// per clock around a ripple-carry adder and gives a 2N-bit product after N steps.
//
// state | meaning
// IDLE  | waiting for start, product held
// RUN   | one add/shift step per edge, N steps total
// DONE  | product valid, done pulse; start here chains the next operation
module seq_shift_add_mult #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   m_q, m_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [N-1:0]   q_q, q_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [2*N-1:0] p_q, p_d;

    logic [N-1:0]   sum;
    logic           c_out;
    logic [N:0]     step_hi;

    rcanbit #(.n(N)) u_add (
        .x     (acc_q),
        .y     (m_q),
        .c_in  (1'b0),
        .s     (sum),
        .c_out (c_out)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        // The carry-out becomes the new top bit of A after the shift.
        step_hi = q_q[0] ? {c_out, sum} : {1'b0, acc_q};

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                {acc_d, q_d} = {step_hi, q_q[N-1:1]};
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    p_d     = {step_hi, q_q[N-1:1]};
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            p_q     <= p_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule

// N-bit ripple-carry adder: the carry runs through n full-adder stages.
module rcanbit #(
    parameter int n = 4
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         c_in,
    output logic [n-1:0] s,
    output logic         c_out
);

    logic carry;

    always_comb begin
        s     = '0;
        carry = c_in;
        for (int i = 0; i < n; i++) begin
            s[i]  = x[i] ^ y[i] ^ carry;
            carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        c_out = carry;
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed and randomized bench for seq_shift_add_mult at N=4 and N=8. The
// expected products are the integer products a*b.
module tb_seq_shift_add_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, start8;
    logic [3:0]  a4, b4;
    logic [7:0]  a8, b8;
    logic        busy4, done4, busy8, done8;
    logic [7:0]  p4;
    logic [15:0] p8;

    int total = 0;
    int bad   = 0;
    logic [31:0] last4 = '0;
    logic [31:0] last8 = '0;

    always #5 clk = ~clk;

    seq_shift_add_mult #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .p(p4)
    );

    seq_shift_add_mult #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .p(p8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_busy(input bit wide);
        return wide ? {31'd0, busy8} : {31'd0, busy4};
    endfunction

    function automatic logic [31:0] get_done(input bit wide);
        return wide ? {31'd0, done8} : {31'd0, done4};
    endfunction

    function automatic logic [31:0] get_p(input bit wide);
        return wide ? {16'd0, p8} : {24'd0, p4};
    endfunction

    task automatic set_start(input bit wide, input bit s, input int av, input int bv);
        if (wide) begin
            start8 = s; a8 = av[7:0]; b8 = bv[7:0];
        end else begin
            start4 = s; a4 = av[3:0]; b4 = bv[3:0];
        end
    endtask

    // One pulsed-start multiply with full cycle-by-cycle timing checks.
    task automatic mult(input bit wide, input int av, input int bv, input string tag);
        int n;
        logic [31:0] exp;
        logic [31:0] prev;
        n    = wide ? 8 : 4;
        exp  = av * bv;
        prev = wide ? last8 : last4;
        set_start(wide, 1'b1, av, bv);
        tick();
        set_start(wide, 1'b0, int'($urandom), int'($urandom));
        for (int k = 1; k <= n; k++) begin
            chk({tag, "_busy"}, get_busy(wide), 32'd1);
            chk({tag, "_nodone"}, get_done(wide), 32'd0);
            chk({tag, "_phold"}, get_p(wide), prev);
            tick();
        end
        chk({tag, "_done"}, get_done(wide), 32'd1);
        chk({tag, "_idlebusy"}, get_busy(wide), 32'd0);
        chk({tag, "_p"}, get_p(wide), exp);
        if (wide) last8 = exp; else last4 = exp;
        tick();
        chk({tag, "_donefall"}, get_done(wide), 32'd0);
        chk({tag, "_pafter"}, get_p(wide), exp);
    endtask

    initial begin
        rst = 1'b1;
        set_start(1'b0, 1'b0, 0, 0);
        set_start(1'b1, 1'b0, 0, 0);

        // reset and idle
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_busy", get_busy(0), 32'd0);
            chk("rst_done", get_done(0), 32'd0);
            chk("rst_p", get_p(0), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_busy", get_busy(0), 32'd0);
            chk("idle_done", get_done(0), 32'd0);
            chk("idle_p", get_p(0), 32'd0);
            chk("idle8_p", get_p(1), 32'd0);
        end

        mult(1'b0, 13, 11, "m13x11");
        mult(1'b0, 0, 9, "m0x9");
        mult(1'b0, 15, 1, "m15x1");
        mult(1'b0, 15, 15, "m15x15");
        mult(1'b1, 255, 255, "m255x255");

        // start while busy is ignored
        set_start(1'b0, 1'b1, 3, 5);
        tick();
        set_start(1'b0, 1'b0, 0, 0);
        tick();
        set_start(1'b0, 1'b1, 7, 7);
        tick();
        set_start(1'b0, 1'b0, 0, 0);
        tick();
        chk("ign_busy", get_busy(0), 32'd1);
        tick();
        chk("ign_done", get_done(0), 32'd1);
        chk("ign_p", get_p(0), 32'd15);
        last4 = 32'd15;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("ign_nodone", get_done(0), 32'd0);
            chk("ign_nobusy", get_busy(0), 32'd0);
        end

        // back-to-back with start held high
        set_start(1'b0, 1'b1, 6, 7);
        for (int i = 0; i < 4; i++) tick();
        chk("b2b_busy1", get_busy(0), 32'd1);
        tick();
        chk("b2b_done1", get_done(0), 32'd1);
        chk("b2b_p1", get_p(0), 32'd42);
        set_start(1'b0, 1'b1, 9, 9);
        tick();
        set_start(1'b0, 1'b0, 0, 0);
        chk("b2b_reaccept", get_busy(0), 32'd1);
        chk("b2b_phold", get_p(0), 32'd42);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b2b_nodone", get_done(0), 32'd0);
        end
        tick();
        chk("b2b_done2", get_done(0), 32'd1);
        chk("b2b_p2", get_p(0), 32'd81);
        tick();

        // reset mid-operation
        set_start(1'b0, 1'b1, 12, 12);
        tick();
        set_start(1'b0, 1'b0, 0, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", get_busy(0), 32'd0);
        chk("mrst_done", get_done(0), 32'd0);
        chk("mrst_p", get_p(0), 32'd0);
        last4 = '0;
        last8 = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mrst_nodone", get_done(0), 32'd0);
        end
        mult(1'b0, 2, 3, "m2x3");

        // randomized operands with idle gaps
        for (int i = 0; i < 16; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) tick();
            mult(1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rnd4");
        end
        for (int i = 0; i < 5; i++) begin
            mult(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), "rnd8");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
